// File: rtl/branch_update_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_update_if
//  Brief    : Two-requester branch update bus and single predictor update port.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_update_if #(
   parameter int ID_BITS = 6
);
   logic [1:0]              IN_valid;
   logic [1:0][31:0]        IN_addr;
   logic [1:0][31:0]        IN_dest;
   logic [1:0]              IN_taken;
   logic [1:0]              IN_isJump;
   logic [1:0][ID_BITS-1:0] IN_branchID;
   logic                    IN_flush;
   logic [1:0]              OUT_ready;
   logic                    OUT_branchValid;
   logic [31:0]             OUT_branchAddr;
   logic [31:0]             OUT_branchDest;
   logic                    OUT_branchTaken;
   logic                    OUT_branchIsJump;
   logic [ID_BITS-1:0]      OUT_branchID;
   logic                    OUT_full;

   modport master (
      output IN_valid, IN_addr, IN_dest, IN_taken, IN_isJump, IN_branchID, IN_flush,
      input  OUT_ready, OUT_branchValid, OUT_branchAddr, OUT_branchDest,
             OUT_branchTaken, OUT_branchIsJump, OUT_branchID, OUT_full
   );

   modport slave (
      input  IN_valid, IN_addr, IN_dest, IN_taken, IN_isJump, IN_branchID, IN_flush,
      output OUT_ready, OUT_branchValid, OUT_branchAddr, OUT_branchDest,
             OUT_branchTaken, OUT_branchIsJump, OUT_branchID, OUT_full
   );
endinterface
`default_nettype wire

// File: rtl/branch_update_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : branch_update_arbiter
//  Brief    : Round-robin merge of two branch-unit updates into a FIFO that
//             drains one update per cycle to the predictor. Optional macro
//             BRANCH_UPDATE_FILTER_EN drops non-qualifying updates at accept.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_update_arbiter #(
   parameter int DEPTH   = 4,
   parameter int ID_BITS = 6
) (
   input  wire logic          clk,
   input  wire logic          rst,
   branch_update_if.slave     bus
);
   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

   typedef struct packed {
      logic [31:0]        addr;
      logic [31:0]        dest;
      logic               taken;
      logic               is_jump;
      logic [ID_BITS-1:0] id;
   } entry_t;

   entry_t               mem_q [DEPTH];
   entry_t               mem_d [DEPTH];
   logic [c_PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [c_CNT_W-1:0]   count_q, count_d;
   logic                 rr_q, rr_d;

   logic [1:0]           grant, ready;
   logic                 sel, filtered, room, accept, enq, deq, out_valid;
   entry_t               in_entry, head_entry;

   always_comb begin
      grant = bus.IN_valid;
      if (bus.IN_valid == 2'b11) begin
         grant = rr_q ? 2'b10 : 2'b01;
      end
      sel      = grant[1];
      in_entry = '{addr:    bus.IN_addr[sel],
                   dest:    bus.IN_dest[sel],
                   taken:   bus.IN_taken[sel],
                   is_jump: bus.IN_isJump[sel],
                   id:      bus.IN_branchID[sel]};
`ifdef BRANCH_UPDATE_FILTER_EN
      // Filtered requests never occupy a slot, so they may pass a full queue.
      filtered = !bus.IN_taken[sel] || (bus.IN_branchID[sel] != '1);
      room     = (count_q < c_DEPTH) || filtered;
`else
      filtered = 1'b0;
      room     = (count_q < c_DEPTH);
`endif
      ready  = grant & {2{room & !bus.IN_flush & !rst}};
      accept = |(bus.IN_valid & ready);
      enq    = accept & !filtered;
      deq    = (count_q != '0);

      mem_d = mem_q;
      if (enq) begin
         mem_d[tail_q] = in_entry;
      end
      head_d  = deq ? head_q + c_PTR_W'(1) : head_q;
      tail_d  = enq ? tail_q + c_PTR_W'(1) : tail_q;
      count_d = count_q + c_CNT_W'(enq) - c_CNT_W'(deq);
      rr_d    = accept ? !sel : rr_q;
      if (bus.IN_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rr_q    <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rr_q    <= rr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Head is consumed unconditionally whenever it is presented.
   always_comb begin
      head_entry           = mem_q[head_q];
      out_valid            = deq & !rst;
      bus.OUT_ready        = ready;
      bus.OUT_branchValid  = out_valid;
      bus.OUT_branchAddr   = out_valid ? head_entry.addr    : 32'd0;
      bus.OUT_branchDest   = out_valid ? head_entry.dest    : 32'd0;
      bus.OUT_branchTaken  = out_valid ? head_entry.taken   : 1'b0;
      bus.OUT_branchIsJump = out_valid ? head_entry.is_jump : 1'b0;
      bus.OUT_branchID     = out_valid ? head_entry.id      : '0;
      bus.OUT_full         = (count_q == c_DEPTH) & !rst;
   end
endmodule
`default_nettype wire
